// File: rtl/pipelined_addsub_stream.sv
// Streaming add/subtract split into STAGES carry-chained chunk adders, one register
// boundary per chunk, with valid tagging, signed-overflow flag and output backpressure.
module pipelined_addsub_stream #(
  parameter int unsigned WIDTH  = 128,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned CW    = CHUNK + 1;
  localparam int unsigned LAST  = STAGES - 1;
  localparam int unsigned MSB   = WIDTH - 1;

  logic              adv_c;
  logic [WIDTH-1:0]  b_prep;
  logic              c0;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cry_q, cry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];

  logic [WIDTH-1:0]  src_a, src_b, src_s;
  logic              src_c, src_v;
  logic [CW-1:0]     part;
  int                kp;

  // Operands ride along in full so the last stage still sees the MSBs for overflow;
  // chunks nobody reads are dead logic and drop out in synthesis.
  always_comb begin
    adv_c  = out_ready | ~vld_q[LAST];
    b_prep = in_sub ? ~in_b : in_b;
    c0     = in_sub ? ~in_cin : in_cin;
    vld_d  = vld_q;
    cry_d  = cry_q;
    a_d    = a_q;
    b_d    = b_q;
    sum_d  = sum_q;
    src_a  = '0;
    src_b  = '0;
    src_s  = '0;
    src_c  = 1'b0;
    src_v  = 1'b0;
    part   = '0;
    kp     = 0;
    if (adv_c) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        kp = (k > 0) ? k - 1 : 0;
        if (k == 0) begin
          src_a = in_a;
          src_b = b_prep;
          src_s = '0;
          src_c = c0;
          src_v = in_valid;
        end else begin
          src_a = a_q[kp];
          src_b = b_q[kp];
          src_s = sum_q[kp];
          src_c = cry_q[kp];
          src_v = vld_q[kp];
        end
        vld_d[k] = src_v;
        // Bubbles leave the data registers untouched.
        if (src_v) begin
          part     = CW'(src_a[k*CHUNK +: CHUNK]) + CW'(src_b[k*CHUNK +: CHUNK]) + CW'(src_c);
          a_d[k]   = src_a;
          b_d[k]   = src_b;
          sum_d[k] = src_s;
          sum_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
          cry_d[k] = part[CHUNK];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      cry_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      cry_q <= cry_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
    end
  end

  assign in_ready  = adv_c;
  assign out_valid = vld_q[LAST];
  assign out_sum   = sum_q[LAST];
  assign out_cout  = cry_q[LAST];
  assign out_ovf   = (a_q[LAST][MSB] == b_q[LAST][MSB]) & (sum_q[LAST][MSB] != a_q[LAST][MSB]);

endmodule

// File: tb/tb_pipelined_addsub_stream.sv
// Directed bench for pipelined_addsub_stream at 128/4, 64/2 and 16/1.
module tb_pipelined_addsub_stream;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tv = 1'b0, tr = 1'b1, tcin = 1'b0, tsub = 1'b0;
  logic [127:0] op_a = '0, op_b = '0;
  int           sel = 0;

  logic         r128, v128, c128, o128;
  logic         r64, v64, c64, o64;
  logic         r16, v16, c16, o16;
  logic [127:0] s128;
  logic [63:0]  s64;
  logic [15:0]  s16;

  logic         obs_v, obs_r, obs_c, obs_o;
  logic [127:0] obs_s;

  int           n_chk = 0, n_pass = 0;
  int           sent, rcv, stall;
  logic         acc, exp_v;
  logic [127:0] m;

  always #5 clk = ~clk;

  pipelined_addsub_stream #(.WIDTH(128), .STAGES(4)) u_dut128 (
    .clk(clk), .rst(rst), .in_valid(tv && sel == 0), .in_ready(r128),
    .in_a(op_a), .in_b(op_b), .in_cin(tcin), .in_sub(tsub),
    .out_valid(v128), .out_ready(tr), .out_sum(s128), .out_cout(c128), .out_ovf(o128));

  pipelined_addsub_stream #(.WIDTH(64), .STAGES(2)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(tv && sel == 1), .in_ready(r64),
    .in_a(op_a[63:0]), .in_b(op_b[63:0]), .in_cin(tcin), .in_sub(tsub),
    .out_valid(v64), .out_ready(tr), .out_sum(s64), .out_cout(c64), .out_ovf(o64));

  pipelined_addsub_stream #(.WIDTH(16), .STAGES(1)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(tv && sel == 2), .in_ready(r16),
    .in_a(op_a[15:0]), .in_b(op_b[15:0]), .in_cin(tcin), .in_sub(tsub),
    .out_valid(v16), .out_ready(tr), .out_sum(s16), .out_cout(c16), .out_ovf(o16));

  always_comb begin
    obs_v = v128; obs_r = r128; obs_c = c128; obs_o = o128; obs_s = s128;
    if (sel == 1) begin
      obs_v = v64; obs_r = r64; obs_c = c64; obs_o = o64; obs_s = {64'b0, s64};
    end else if (sel == 2) begin
      obs_v = v16; obs_r = r16; obs_c = c16; obs_o = o16; obs_s = {112'b0, s16};
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] mask(input int s);
    case (s)
      0:       return {128{1'b1}};
      1:       return {64'b0, {64{1'b1}}};
      default: return {112'b0, {16{1'b1}}};
    endcase
  endfunction

  function automatic int lat(input int s);
    case (s)
      0:       return 4;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  // Single beat through an empty pipe; called #1 after a rising edge.
  task automatic run_op(input string tag, input logic [127:0] a, input logic [127:0] b,
                        input logic cin, input logic sub,
                        input logic [127:0] es, input logic ec, input logic eo);
    int n;
    op_a = a; op_b = b; tcin = cin; tsub = sub; tv = 1'b1;
    @(posedge clk); #1;
    tv = 1'b0;
    n  = 1;
    while (!obs_v && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("%s w%0d latency", tag, sel), 128'(n), 128'(lat(sel)));
    check($sformatf("%s w%0d sum", tag, sel), obs_s, es);
    check($sformatf("%s w%0d cout", tag, sel), 128'(obs_c), 128'(ec));
    check($sformatf("%s w%0d ovf", tag, sel), 128'(obs_o), 128'(eo));
    @(posedge clk); #1;
    check($sformatf("%s w%0d pulse", tag, sel), 128'(obs_v), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check($sformatf("reset w%0d valid", s), 128'(obs_v), 128'(0));
      check($sformatf("reset w%0d sum", s), obs_s, 128'(0));
      check($sformatf("reset w%0d cout", s), 128'(obs_c), 128'(0));
      check($sformatf("reset w%0d ovf", s), 128'(obs_o), 128'(0));
      check($sformatf("reset w%0d in_ready", s), 128'(obs_r), 128'(1));
    end
    rst = 1'b1;
    @(posedge clk); #1;

    sel = 0;
    run_op("zero", '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      m   = mask(s);
      run_op("carry", m, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      run_op("ovf", m >> 1, 128'd1, 1'b0, 1'b0, (m >> 1) + 128'd1, 1'b0, 1'b1);
      run_op("sub5-7", 128'd5, 128'd7, 1'b0, 1'b1, m - 128'd1, 1'b0, 1'b0);
      run_op("sub7-5", 128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1, 1'b0);
    end

    // Streaming: beat c accepted on edge c, visible after edge c+3.
    sel = 0;
    for (int c = 0; c < 110; c++) begin
      tv = (c < 100); op_a = 128'(c); op_b = 128'(c); tcin = 1'b0; tsub = 1'b0;
      @(posedge clk); #1;
      exp_v = (c >= 3 && c < 103);
      check($sformatf("stream valid c%0d", c), 128'(obs_v), 128'(exp_v));
      if (exp_v) check($sformatf("stream sum c%0d", c), obs_s, 128'(2 * (c - 3)));
    end
    tv = 1'b0;

    // Backpressure: 10 beats of (i+1)+10, stall 3 cycles after the 2nd result.
    sent = 0; rcv = 0; stall = 0;
    for (int c = 0; c < 80 && rcv < 10; c++) begin
      tr = (stall == 0);
      tv = (sent < 10); op_a = 128'(sent + 1); op_b = 128'd10; tcin = 1'b0; tsub = 1'b0;
      #1;
      acc = tv && obs_r;
      if (stall > 0) begin
        check("bp in_ready", 128'(obs_r), 128'(0));
        check("bp valid held", 128'(obs_v), 128'(1));
        check("bp sum held", obs_s, 128'(rcv + 11));
        stall--;
      end else if (obs_v) begin
        check($sformatf("bp sum %0d", rcv), obs_s, 128'(rcv + 11));
        rcv++;
        if (rcv == 2) stall = 3;
      end
      if (acc) sent++;
      @(posedge clk); #1;
    end
    check("bp results", 128'(rcv), 128'(10));
    tr = 1'b1; tv = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("bp no extra", 128'(obs_v), 128'(0));

    // Reset with two beats still in flight.
    for (int c = 0; c < 5; c++) begin
      tv = (c < 4); op_a = 128'(c + 50); op_b = '0; tcin = 1'b0; tsub = 1'b0;
      @(posedge clk); #1;
    end
    tv = 1'b0;
    check("pre-reset valid", 128'(obs_v), 128'(1));
    check("pre-reset sum", obs_s, 128'd51);
    #2;
    rst = 1'b0;
    #1;
    check("mid reset valid", 128'(obs_v), 128'(0));
    check("mid reset sum", obs_s, 128'(0));
    check("mid reset in_ready", 128'(obs_r), 128'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check($sformatf("post reset valid c%0d", c), 128'(obs_v), 128'(0));
    end
    run_op("after reset", 128'd9, 128'd3, 1'b1, 1'b0, 128'd13, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
